mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Parametrised successor to the pass-through MEM stage of the 5-stage MIPS pipeline.
- Sits between EX and WB and performs real data-memory accesses: LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data bus.
- Raises a stall while a bus access is outstanding and registers the MEM/WB pipeline values.
- Forwards HI/LO writes and register-write controls unchanged for non-memory ops.

Parameters:
- ADDR_W, 32, data-bus address width (bits above 32 are zero-extended from result).
- REG_ADDR_W, 5, destination register address width.
- TIMEOUT, 15, maximum cycles waiting for dmem_ack before abort; range 1..255.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents a valid instruction this cycle
- mem_op  in  4  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; others are treated as none
- en_wd  in  1  register write enable from EX
- desReg_addr  in  REG_ADDR_W  destination register
- result  in  32  ALU result; the effective address for memory ops
- store_data  in  32  rt value for stores
- hi_i, lo_i  in  32 each  HI/LO values
- en_hilo_i  in  1  HI/LO write enable
- flush  in  1  discard the instruction held or accepted this cycle
- stall_req  out  1  hold EX and earlier stages
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  bus completes the access this cycle
- dmem_rdata  in  32  read word, valid with ack
- wb_valid  out  1  WB registers hold a valid instruction
- en_wd_wb  out  1  register write enable to WB
- desReg_addr_wb  out  REG_ADDR_W  destination register to WB
- result_wb  out  32  write-back data
- hi_o, lo_o  out  32 each  HI/LO to WB
- en_hilo_o  out  1  HI/LO write enable to WB
- exc_wb  out  2  bit0 = misaligned, bit1 = bus timeout

Behaviour:
- Reset (rst_n low, asynchronous):
  - every output 0; FSM in IDLE; timeout counter 0.
  - Reset asserted mid-access drops dmem_req immediately; a late ack is ignored.
- FSM states: IDLE and BUSY.
- IDLE, ex_valid=1, non-memory op:
  - WB registers load the EX values at the next edge.
  - wb_valid=1; exc_wb=0; stall_req=0; latency 1 cycle.
- IDLE, ex_valid=1, memory op:
  - stall_req=1 combinationally.
  - At the edge: latch op/address/data, drive dmem_req/we/addr/be/wdata as registers, go to BUSY.
  - wb_valid=0 that edge.
- IDLE, ex_valid=0: wb_valid=0 at the next edge; other WB registers hold.
- BUSY:
  - dmem_* held stable until ack.
  - stall_req = !dmem_ack.
  - Counter increments each cycle without ack.
- Ack in BUSY:
  - dmem_req drops at the next edge; state returns to IDLE.
  - WB loads with wb_valid=1.
  - Minimum load latency is 2 cycles from acceptance.
- Load formatting, by byte offset a=result[1:0]:
  - LB/LBU select byte a, sign- or zero-extended.
  - LH/LHU select half a[1], sign- or zero-extended.
  - LW takes the full word.
  - en_wd_wb follows en_wd.
- Store formatting:
  - SB: be = 1<<a; data replicated ×4.
  - SH: be = 0011 or 1100; data replicated ×2.
  - SW: be = 1111.
  - Stores complete with en_wd_wb=0.
- Timeout: counter reaches TIMEOUT without ack →
  - dmem_req drops; state returns to IDLE.
  - wb_valid=1, en_wd_wb=0, exc_wb[1]=1.
- flush:
  - In IDLE: the accepted instruction is dropped; no request is issued and wb_valid=0 next edge.
  - In BUSY: the bus access still runs to ack or timeout, but completes with wb_valid=0 and no exception.
- Ack in the same cycle as flush: treated as flushed.
- Ack while in IDLE: ignored.
- HI/LO signals pass through with the instruction in all cases; en_hilo_o is forced to 0 when wb_valid=0.

Optional Feature:
- Macro: MEM_ALIGN_EXC_EN.
- Defined: misaligned accesses (half with a[0]=1, word with a!=0) issue no bus request. WB loads next edge with wb_valid=1, en_wd_wb=0, exc_wb[0]=1, and no stall.
- Undefined: low address bits are ignored for half/word alignment (half uses a[1], word uses 00); exc_wb[0] is always 0.

Test Plan:
- Reset mid-BUSY:
  - stimulus: assert rst_n=0 with dmem_req=1, then ack 1 cycle after release.
  - response: all outputs 0 immediately; late ack produces no wb_valid.
- Non-memory op:
  - stimulus: ex_valid=1, mem_op=0, result=0x1234_5678, desReg_addr=3, en_wd=1.
  - response: next cycle wb_valid=1, result_wb=0x1234_5678, stall_req never high.
- Signed/unsigned byte load:
  - stimulus: LB at result=0x103, ack after 2 wait cycles with rdata=0x80FF_0000.
  - response: dmem_addr=0x100, stall 3 cycles, result_wb=0xFFFF_FF80.
  - repeat with LBU: result_wb=0x0000_0080.
- Half store:
  - stimulus: SH at 0x202, store_data=0x0000_BEEF.
  - response: dmem_we=1, dmem_be=1100, dmem_wdata=0xBEEF_BEEF, en_wd_wb=0 after ack.
- Timeout:
  - stimulus: LW at 0x40 with no ack, TIMEOUT=15.
  - response: dmem_req drops after 15 wait cycles; exc_wb=2'b10, en_wd_wb=0.
- Flush during BUSY (with MEM_ALIGN_EXC_EN defined):
  - stimulus: flush during BUSY, then ack.
  - response: wb_valid stays 0.
  - then LW at 0x41: no dmem_req, exc_wb=2'b01 the next cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: issues LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack bus and registers MEM/WB values.
// Define MEM_ALIGN_EXC_EN to trap misaligned half/word accesses instead of issuing them.
module mem_access_stage #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [3:0]            mem_op,
  input  logic                  en_wd,
  input  logic [REG_ADDR_W-1:0] desReg_addr,
  input  logic [31:0]           result,
  input  logic [31:0]           store_data,
  input  logic [31:0]           hi_i,
  input  logic [31:0]           lo_i,
  input  logic                  en_hilo_i,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [31:0]           dmem_rdata,
  output logic                  wb_valid,
  output logic                  en_wd_wb,
  output logic [REG_ADDR_W-1:0] desReg_addr_wb,
  output logic [31:0]           result_wb,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  en_hilo_o,
  output logic [1:0]            exc_wb
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  // Access state
  logic [0:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [3:0]            op_q, op_d;
  logic [1:0]            off_q, off_d;
  logic                  en_wd_q, en_wd_d;
  logic [REG_ADDR_W-1:0] dreg_q, dreg_d;
  logic [31:0]           res_q, res_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;
  logic                  en_hilo_q, en_hilo_d;
  logic                  flushed_q, flushed_d;

  // Bus registers
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;

  // MEM/WB registers
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_en_wd_q, wb_en_wd_d;
  logic [REG_ADDR_W-1:0] wb_dreg_q, wb_dreg_d;
  logic [31:0]           wb_result_q, wb_result_d;
  logic [31:0]           wb_hi_q, wb_hi_d;
  logic [31:0]           wb_lo_q, wb_lo_d;
  logic                  wb_en_hilo_q, wb_en_hilo_d;
  logic [1:0]            wb_exc_q, wb_exc_d;

  logic                  is_load_in, is_store_in, is_mem_in, misalign_in;
  logic                  is_load_q, timeout_hit;
  logic [ADDR_W-1:0]     addr_in;
  logic [3:0]            be_in;
  logic [31:0]           wdata_in;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_data;

  assign is_load_in  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
  assign is_store_in = (mem_op >= OP_SB) && (mem_op <= OP_SW);
  assign is_mem_in   = is_load_in | is_store_in;
  assign is_load_q   = (op_q >= OP_LB) && (op_q <= OP_LW);

`ifdef MEM_ALIGN_EXC_EN
  assign misalign_in = (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH)) &&
                        result[0]) ||
                       (((mem_op == OP_LW) || (mem_op == OP_SW)) && (result[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  assign timeout_hit = (state_q == BUSY) && !dmem_ack && (cnt_q == TIMEOUT_LAST);

  // Gated by rst_n so every output reads 0 while reset is held.
  assign stall_req = rst_n & ((state_q == IDLE) ?
                              (ex_valid & is_mem_in & ~flush & ~misalign_in) : ~dmem_ack);

  // Request formatting: byte/half lanes chosen from the low address bits.
  always_comb begin
    addr_in       = ADDR_W'(result);
    addr_in[1:0]  = 2'b00;
    be_in         = 4'b0000;
    wdata_in      = 32'h0;
    case (mem_op)
      OP_LB, OP_LBU: be_in = 4'b0001 << result[1:0];
      OP_LH, OP_LHU: be_in = result[1] ? 4'b1100 : 4'b0011;
      OP_LW:         be_in = 4'b1111;
      OP_SB: begin
        be_in    = 4'b0001 << result[1:0];
        wdata_in = {4{store_data[7:0]}};
      end
      OP_SH: begin
        be_in    = result[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{store_data[15:0]}};
      end
      OP_SW: begin
        be_in    = 4'b1111;
        wdata_in = store_data;
      end
      default: ;
    endcase
  end

  // Load formatting from the returned word.
  always_comb begin
    ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'h0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    off_d        = off_q;
    en_wd_d      = en_wd_q;
    dreg_d       = dreg_q;
    res_d        = res_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    en_hilo_d    = en_hilo_q;
    flushed_d    = flushed_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    // Valid, HI/LO enable and exception only survive a completing instruction.
    wb_valid_d   = 1'b0;
    wb_en_hilo_d = 1'b0;
    wb_exc_d     = 2'b00;
    wb_en_wd_d   = wb_en_wd_q;
    wb_dreg_d    = wb_dreg_q;
    wb_result_d  = wb_result_q;
    wb_hi_d      = wb_hi_q;
    wb_lo_d      = wb_lo_q;

    unique case (state_q)
      IDLE: begin
        if (ex_valid && !flush) begin
          if (is_mem_in && !misalign_in) begin
            state_d   = BUSY;
            cnt_d     = 8'd0;
            flushed_d = 1'b0;
            op_d      = mem_op;
            off_d     = result[1:0];
            en_wd_d   = en_wd;
            dreg_d    = desReg_addr;
            res_d     = result;
            hi_d      = hi_i;
            lo_d      = lo_i;
            en_hilo_d = en_hilo_i;
            req_d     = 1'b1;
            we_d      = is_store_in;
            addr_d    = addr_in;
            be_d      = be_in;
            wdata_d   = wdata_in;
          end else begin
            // Non-memory op, or a trapped misaligned access.
            wb_valid_d   = 1'b1;
            wb_en_wd_d   = en_wd & ~is_mem_in;
            wb_dreg_d    = desReg_addr;
            wb_result_d  = result;
            wb_hi_d      = hi_i;
            wb_lo_d      = lo_i;
            wb_en_hilo_d = en_hilo_i;
            wb_exc_d     = {1'b0, is_mem_in};
          end
        end
      end
      BUSY: begin
        if (flush) flushed_d = 1'b1;
        if (dmem_ack || timeout_hit) begin
          state_d   = IDLE;
          cnt_d     = 8'd0;
          flushed_d = 1'b0;
          req_d     = 1'b0;
          we_d      = 1'b0;
          addr_d    = '0;
          be_d      = 4'b0000;
          wdata_d   = 32'h0;
          wb_dreg_d = dreg_q;
          wb_hi_d   = hi_q;
          wb_lo_d   = lo_q;
          if (!(flushed_q || flush)) begin
            wb_valid_d   = 1'b1;
            wb_en_hilo_d = en_hilo_q;
            if (dmem_ack) begin
              wb_en_wd_d  = en_wd_q & is_load_q;
              wb_result_d = is_load_q ? ld_data : res_q;
            end else begin
              wb_en_wd_d  = 1'b0;
              wb_result_d = res_q;
              wb_exc_d    = 2'b10;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      op_q         <= 4'd0;
      off_q        <= 2'd0;
      en_wd_q      <= 1'b0;
      dreg_q       <= '0;
      res_q        <= 32'h0;
      hi_q         <= 32'h0;
      lo_q         <= 32'h0;
      en_hilo_q    <= 1'b0;
      flushed_q    <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= 4'b0000;
      wdata_q      <= 32'h0;
      wb_valid_q   <= 1'b0;
      wb_en_wd_q   <= 1'b0;
      wb_dreg_q    <= '0;
      wb_result_q  <= 32'h0;
      wb_hi_q      <= 32'h0;
      wb_lo_q      <= 32'h0;
      wb_en_hilo_q <= 1'b0;
      wb_exc_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      off_q        <= off_d;
      en_wd_q      <= en_wd_d;
      dreg_q       <= dreg_d;
      res_q        <= res_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      en_hilo_q    <= en_hilo_d;
      flushed_q    <= flushed_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_en_wd_q   <= wb_en_wd_d;
      wb_dreg_q    <= wb_dreg_d;
      wb_result_q  <= wb_result_d;
      wb_hi_q      <= wb_hi_d;
      wb_lo_q      <= wb_lo_d;
      wb_en_hilo_q <= wb_en_hilo_d;
      wb_exc_q     <= wb_exc_d;
    end
  end

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign wb_valid       = wb_valid_q;
  assign en_wd_wb       = wb_en_wd_q;
  assign desReg_addr_wb = wb_dreg_q;
  assign result_wb      = wb_result_q;
  assign hi_o           = wb_hi_q;
  assign lo_o           = wb_lo_q;
  assign en_hilo_o      = wb_en_hilo_q;
  assign exc_wb         = wb_exc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed cases plus randomized ops vs. a reference model.
module tb_mem_access_stage;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned TIMEOUT    = 15;
`ifdef MEM_ALIGN_EXC_EN
  localparam bit AlignExc = 1'b1;
`else
  localparam bit AlignExc = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, en_wd, en_hilo_i, flush, dmem_ack;
  logic [3:0]  mem_op;
  logic [4:0]  desReg_addr;
  logic [31:0] result, store_data, hi_i, lo_i, dmem_rdata;
  logic        stall_req, dmem_req, dmem_we, wb_valid, en_wd_wb, en_hilo_o;
  logic [31:0] dmem_addr, dmem_wdata, result_wb, hi_o, lo_o;
  logic [3:0]  dmem_be;
  logic [4:0]  desReg_addr_wb;
  logic [1:0]  exc_wb;

  mem_access_stage #(
    .ADDR_W    (ADDR_W),
    .REG_ADDR_W(REG_ADDR_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .mem_op        (mem_op),
    .en_wd         (en_wd),
    .desReg_addr   (desReg_addr),
    .result        (result),
    .store_data    (store_data),
    .hi_i          (hi_i),
    .lo_i          (lo_i),
    .en_hilo_i     (en_hilo_i),
    .flush         (flush),
    .stall_req     (stall_req),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .en_wd_wb      (en_wd_wb),
    .desReg_addr_wb(desReg_addr_wb),
    .result_wb     (result_wb),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .en_hilo_o     (en_hilo_o),
    .exc_wb        (exc_wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dreg;
    logic        en_wd;
    logic        chk_res;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        en_hilo;
    logic [1:0]  exc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
    end
  endtask

  // Reference load formatting: pick the addressed byte/half of the word and extend it.
  function automatic logic [31:0] load_model(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int unsigned a, b, h;
    a = addr % 4;
    b = (rd >> (8 * a)) & 32'hFF;
    h = (rd >> (16 * (a / 2))) & 32'hFFFF;
    case (op)
      4'd1:    return (b >= 128) ? b - 256 : b;
      4'd2:    return b;
      4'd3:    return (h >= 32768) ? h - 65536 : h;
      4'd4:    return h;
      default: return rd;
    endcase
  endfunction

  // Monitor: every wb_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wb_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_wb: wb_valid=1, want no completion");
        end else begin
          mon_e = sb_q.pop_front();
          check("wb_dreg", 32'(desReg_addr_wb), 32'(mon_e.dreg));
          check("wb_en_wd", 32'(en_wd_wb), 32'(mon_e.en_wd));
          check("wb_exc", 32'(exc_wb), 32'(mon_e.exc));
          check("wb_hi", hi_o, mon_e.hi);
          check("wb_lo", lo_o, mon_e.lo);
          check("wb_en_hilo", 32'(en_hilo_o), 32'(mon_e.en_hilo));
          if (mon_e.chk_res) check("wb_result", result_wb, mon_e.res);
        end
      end else begin
        check("en_hilo_invalid", 32'(en_hilo_o), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction through EX->MEM. wait_n: BUSY cycles before ack (-1 = never).
  task automatic do_op(input logic [3:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic ewd, input logic [4:0] dreg, input logic [31:0] hi,
                       input logic [31:0] lo, input logic ehl, input int wait_n,
                       input bit fl_idle, input int fl_busy, input logic [31:0] rd);
    bit          is_load, is_store, mis, done, acked, flushed;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    exp_t        e;
    is_load  = (op >= 1) && (op <= 5);
    is_store = (op >= 6) && (op <= 8);
    mis = AlignExc && ((((op == 3) || (op == 4) || (op == 7)) && res[0]) ||
                       (((op == 5) || (op == 8)) && (res[1:0] != 2'b00)));
    e.dreg = dreg; e.en_wd = ewd; e.chk_res = 1'b1; e.res = res;
    e.hi = hi; e.lo = lo; e.en_hilo = ehl; e.exc = 2'b00;
    exp_be = 4'hF;
    exp_wd = sd;
    if (op == 6) begin
      exp_be = 4'(1 << (res % 4));
      exp_wd = 32'(sd[7:0]) * 32'h0101_0101;
    end else if (op == 7) begin
      exp_be = ((res % 4) >= 2) ? 4'hC : 4'h3;
      exp_wd = 32'(sd[15:0]) * 32'h0001_0001;
    end

    tick();
    ex_valid = 1'b1; mem_op = op; result = res; store_data = sd; en_wd = ewd;
    desReg_addr = dreg; hi_i = hi; lo_i = lo; en_hilo_i = ehl; flush = fl_idle;

    if (fl_idle || !(is_load || is_store) || mis) begin
      if (mis) begin
        e.en_wd = 1'b0; e.chk_res = 1'b0; e.exc = 2'b01;
      end else if (is_load || is_store) begin
        e.en_wd = 1'b0;
      end
      if (!fl_idle) sb_q.push_back(e);
      @(negedge clk);
      check("stall_no_access", 32'(stall_req), 32'd0);
      tick();
      ex_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("wb_valid_next", 32'(wb_valid), 32'(!fl_idle));
      check("no_req", 32'(dmem_req), 32'd0);
    end else begin
      @(negedge clk);
      check("stall_accept", 32'(stall_req), 32'd1);
      tick();
      ex_valid = 1'b0;
      done = 1'b0;
      flushed = 1'b0;
      for (int k = 0; !done; k++) begin
        acked = (wait_n >= 0) && (k == wait_n);
        dmem_ack = acked;
        dmem_rdata = acked ? rd : $urandom;
        flush = (k == fl_busy);
        if (k == fl_busy) flushed = 1'b1;
        @(negedge clk);
        check("req_busy", 32'(dmem_req), 32'd1);
        check("addr", dmem_addr, res & ~32'h3);
        check("we", 32'(dmem_we), 32'(is_store));
        if (is_store) begin
          check("be", 32'(dmem_be), 32'(exp_be));
          check("wdata", dmem_wdata, exp_wd);
        end
        check("stall_busy", 32'(stall_req), 32'(!acked));
        if (acked || (k == int'(TIMEOUT) - 1)) begin
          done = 1'b1;
          if (!flushed) begin
            if (acked && is_load) begin
              e.res = load_model(op, res, rd);
            end else if (acked) begin
              e.en_wd = 1'b0; e.chk_res = 1'b0;
            end else begin
              e.en_wd = 1'b0; e.chk_res = 1'b0; e.exc = 2'b10;
            end
            sb_q.push_back(e);
          end
        end
        tick();
        dmem_ack = 1'b0;
        flush = 1'b0;
      end
      @(negedge clk);
      check("req_drop", 32'(dmem_req), 32'd0);
      check("wb_valid_done", 32'(wb_valid), 32'(!flushed));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          w, fb;
    logic [3:0]  op;
    rst_n = 1'b0; ex_valid = 1'b0; mem_op = 4'd0; en_wd = 1'b0; desReg_addr = 5'd0;
    result = 32'h0; store_data = 32'h0; hi_i = 32'h0; lo_i = 32'h0; en_hilo_i = 1'b0;
    flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;

    #12;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_result_wb", result_wb, 32'd0);
    check("rst_exc", 32'(exc_wb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-access, late ack afterwards.
    tick();
    ex_valid = 1'b1; mem_op = 4'd5; result = 32'h80; en_wd = 1'b1;
    tick();
    ex_valid = 1'b0;
    @(negedge clk);
    check("midrst_req_before", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(dmem_req), 32'd0);
    check("midrst_addr", dmem_addr, 32'd0);
    check("midrst_stall", 32'(stall_req), 32'd0);
    check("midrst_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_wb", 32'(wb_valid), 32'd0);
    check("late_ack_req", 32'(dmem_req), 32'd0);

    // Directed cases
    do_op(4'd0, 32'h1234_5678, 32'h0, 1'b1, 5'd3, 32'hA, 32'hB, 1'b1, 0, 1'b0, -1, 32'h0);
    do_op(4'd1, 32'h103, 32'h0, 1'b1, 5'd4, 32'h1, 32'h2, 1'b0, 2, 1'b0, -1, 32'h80FF_0000);
    do_op(4'd2, 32'h103, 32'h0, 1'b1, 5'd5, 32'h1, 32'h2, 1'b0, 2, 1'b0, -1, 32'h80FF_0000);
    do_op(4'd7, 32'h202, 32'h0000_BEEF, 1'b1, 5'd6, 32'h3, 32'h4, 1'b0, 1, 1'b0, -1, 32'h0);
    do_op(4'd5, 32'h40, 32'h0, 1'b1, 5'd7, 32'h5, 32'h6, 1'b1, -1, 1'b0, -1, 32'h0);
    do_op(4'd5, 32'h300, 32'h0, 1'b1, 5'd8, 32'h7, 32'h8, 1'b1, 2, 1'b0, 1, 32'h1111_2222);
    do_op(4'd5, 32'h41, 32'h0, 1'b1, 5'd9, 32'h9, 32'hA, 1'b0, 1, 1'b0, -1, 32'hCAFE_F00D);
    do_op(4'd6, 32'h500, 32'h0, 1'b1, 5'd10, 32'h0, 32'h0, 1'b0, 0, 1'b1, -1, 32'h0);
    do_op(4'd4, 32'h602, 32'h0, 1'b1, 5'd11, 32'h0, 32'h0, 1'b0, 0, 1'b0, 0, 32'h8001_0002);

    // Ack while idle is ignored
    tick();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_wb", 32'(wb_valid), 32'd0);

    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      w  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      do_op(op, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, $urandom,
            1'($urandom), w, ($urandom_range(0, 9) == 0), fb, $urandom);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
